// File: rtl/ntt_pkg.sv
// ntt_pkg: FSM states, 17-bit address type, latency default and address helpers for the NTT address unit
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef logic [16:0] addr_t;
  localparam int BF_LATENCY_DEF = 4;
  function automatic addr_t pow2_floor(addr_t x);
    addr_t r;
    r = '0;
    for (int i = 0; i < 17; i++) r = x[i] ? addr_t'(1) << i : r;
    return r;
  endfunction
  function automatic addr_t bf_lo(addr_t k, addr_t len);
    addr_t m;
    m = len - addr_t'(1);
    return ((k & ~m) << 1) | (k & m);
  endfunction
endpackage

// File: rtl/ntt_addr_delay_line.sv
// ntt_addr_delay_line: DEPTH-stage shift register (clk, rst sync high, d_i in, q_o = d_i delayed DEPTH cycles)
module ntt_addr_delay_line #(
  parameter int DEPTH = 4,
  parameter int W = 35
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] sr_q [DEPTH];
  logic [W-1:0] sr_d [DEPTH];
  always_comb begin
    sr_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) sr_d[i] = sr_q[i-1];
  end
  always_ff @(posedge clk) begin
    if (rst) sr_q <= '{default: '0};
    else sr_q <= sr_d;
  end
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/ntt_address_unit_register.sv
// ntt_address_unit_register: NTT butterfly address generator (ntt_start/param_n in; raddr*/waddr* pairs and one-hot we_o out)
module ntt_address_unit_register
  import ntt_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int BF_LATENCY = BF_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ntt_start,
  input  logic [16:0]                   param_n,
  output logic [16:0]                   raddr1_o,
  output logic [16:0]                   raddr2_o,
  output logic [16:0]                   waddr1_o,
  output logic [16:0]                   waddr2_o,
  output logic [2**(ADDR_WIDTH-1)-1:0]  we_o
);
  localparam int CW = $clog2(BF_LATENCY + 1);
  localparam int LW = 2 ** (ADDR_WIDTH - 1);
  if (BF_LATENCY < 1 || DATA_WIDTH < 1 || ADDR_WIDTH < 2) begin : g_bad_param
    $error("ntt_address_unit_register: invalid parameter");
  end
  state_t state_q, state_d;
  addr_t half_q, half_d, len_q, len_d, k_q, k_d;
  addr_t raddr1_q, raddr1_d, raddr2_q, raddr2_d, lo_d, n_in;
  logic valid_q, valid_d, stage_end, drain_end, wvalid;
  logic [CW-1:0] cnt_q, cnt_d;
  assign n_in = pow2_floor(param_n);
  assign stage_end = k_q == half_q - 17'd1;
  assign drain_end = cnt_q == CW'(BF_LATENCY - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      half_q   <= '0;
      len_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      raddr1_q <= '0;
      raddr2_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      len_q    <= len_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      raddr1_q <= raddr1_d;
      raddr2_q <= raddr2_d;
      valid_q  <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ntt_start) state_d = n_in < 17'd2 ? DONE : RUN;
      RUN:     if (stage_end) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = len_q == 17'd1 ? DONE : RUN;
      DONE:    if (!ntt_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    half_d  = half_q;
    len_d   = len_q;
    k_d     = k_q;
    cnt_d   = '0;
    valid_d = 1'b0;
    case (state_q)
      IDLE: if (ntt_start) begin
        half_d  = n_in >> 1;
        len_d   = n_in >> 1;
        k_d     = '0;
        valid_d = n_in >= 17'd2;
      end
      RUN: if (!stage_end) begin
        k_d     = k_q + 17'd1;
        valid_d = 1'b1;
      end
      DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (drain_end && len_q != 17'd1) begin
          len_d   = len_q >> 1;
          k_d     = '0;
          valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    lo_d     = bf_lo(k_d, len_d);
    raddr1_d = valid_d ? lo_d : raddr1_q;
    raddr2_d = valid_d ? lo_d | len_d : raddr2_q;
  end
  ntt_addr_delay_line #(.DEPTH(BF_LATENCY), .W(35)) u_delay (
    .clk(clk),
    .rst(rst),
    .d_i({valid_q, raddr1_q, raddr2_q}),
    .q_o({wvalid, waddr1_o, waddr2_o})
  );
  assign raddr1_o = raddr1_q;
  assign raddr2_o = raddr2_q;
  assign we_o = wvalid ? LW'(1) << waddr1_o[ADDR_WIDTH-2:0] : '0;
endmodule

// File: tb/tb_ntt_address_unit_register.sv
// tb_ntt_address_unit_register: randomized self-checking bench against a stage/pair reference model
module tb_ntt_address_unit_register;
  localparam int L = 4;
  logic clk = 1'b0;
  logic rst, ntt_start;
  logic [16:0] param_n, raddr1, raddr2, waddr1, waddr2;
  logic [31:0] we;
  int errors = 0;
  int checks = 0;
  logic [16:0] exp_r1[$];
  logic [16:0] exp_r2[$];
  bit exp_v[$];
  ntt_address_unit_register #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .BF_LATENCY(L)) dut (
    .clk(clk),
    .rst(rst),
    .ntt_start(ntt_start),
    .param_n(param_n),
    .raddr1_o(raddr1),
    .raddr2_o(raddr2),
    .waddr1_o(waddr1),
    .waddr2_o(waddr2),
    .we_o(we)
  );
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end
  task automatic build_model(input int pn);
    int n = 1;
    exp_r1.delete();
    exp_r2.delete();
    exp_v.delete();
    while (n * 2 <= pn) n *= 2;
    if (n < 2) return;
    for (int len = n / 2; len >= 1; len /= 2) begin
      for (int k = 0; k < n / 2; k++) begin
        int j = (k / len) * 2 * len + k % len;
        exp_r1.push_back(17'(j));
        exp_r2.push_back(17'(j + len));
        exp_v.push_back(1'b1);
      end
      for (int d = 0; d < L; d++) begin
        exp_r1.push_back(exp_r1[$]);
        exp_r2.push_back(exp_r2[$]);
        exp_v.push_back(1'b0);
      end
    end
  endtask
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    ntt_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    ntt_start = 1'b0;
    param_n = 17'd256;
    repeat (2) @(negedge clk);
    checks += 5;
    if (raddr1 !== 17'd0) begin errors++; $display("FAIL reset raddr1: got %0d want 0", raddr1); end
    if (raddr2 !== 17'd0) begin errors++; $display("FAIL reset raddr2: got %0d want 0", raddr2); end
    if (waddr1 !== 17'd0) begin errors++; $display("FAIL reset waddr1: got %0d want 0", waddr1); end
    if (waddr2 !== 17'd0) begin errors++; $display("FAIL reset waddr2: got %0d want 0", waddr2); end
    if (we !== 32'd0) begin errors++; $display("FAIL reset we: got %h want 0", we); end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks += 2;
      if (raddr1 !== 17'd0 || raddr2 !== 17'd0) begin errors++; $display("FAIL idle raddr: got %0d,%0d want 0,0", raddr1, raddr2); end
      if (we !== 32'd0) begin errors++; $display("FAIL idle we: got %h want 0", we); end
    end
  endtask
  task automatic test_transform(input int pn, input string tag);
    logic [31:0] ewe;
    bit wv;
    build_model(pn);
    @(negedge clk);
    param_n = 17'(pn);
    ntt_start = 1'b1;
    for (int i = 0; i < exp_v.size(); i++) begin
      @(negedge clk);
      param_n = 17'($urandom);
      wv = i >= L && exp_v[i-L];
      ewe = wv ? 32'd1 << exp_r1[i-L][4:0] : 32'd0;
      checks += 3;
      if (raddr1 !== exp_r1[i]) begin errors++; $display("FAIL %s raddr1 cyc %0d: got %0d want %0d", tag, i, raddr1, exp_r1[i]); end
      if (raddr2 !== exp_r2[i]) begin errors++; $display("FAIL %s raddr2 cyc %0d: got %0d want %0d", tag, i, raddr2, exp_r2[i]); end
      if (we !== ewe) begin errors++; $display("FAIL %s we cyc %0d: got %h want %h", tag, i, we, ewe); end
      if (wv) begin
        checks += 2;
        if (waddr1 !== exp_r1[i-L]) begin errors++; $display("FAIL %s waddr1 cyc %0d: got %0d want %0d", tag, i, waddr1, exp_r1[i-L]); end
        if (waddr2 !== exp_r2[i-L]) begin errors++; $display("FAIL %s waddr2 cyc %0d: got %0d want %0d", tag, i, waddr2, exp_r2[i-L]); end
      end
    end
    ntt_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ntt_start = 1'b1;
      checks += 2;
      if (raddr1 !== exp_r1[$] || raddr2 !== exp_r2[$]) begin errors++; $display("FAIL %s done-hold raddr cyc %0d: got %0d,%0d want %0d,%0d", tag, i, raddr1, raddr2, exp_r1[$], exp_r2[$]); end
      if (we !== 32'd0) begin errors++; $display("FAIL %s done-hold we cyc %0d: got %h want 0", tag, i, we); end
    end
    ntt_start = 1'b0;
    param_n = 17'(pn);
    @(negedge clk);
    ntt_start = 1'b1;
    @(negedge clk);
    checks++;
    if (raddr1 !== exp_r1[0] || raddr2 !== exp_r2[0]) begin errors++; $display("FAIL %s restart pair: got %0d,%0d want %0d,%0d", tag, raddr1, raddr2, exp_r1[0], exp_r2[0]); end
    do_reset();
  endtask
  task automatic test_n256;
    @(negedge clk);
    param_n = 17'd256;
    ntt_start = 1'b1;
    for (int i = 0; i <= 132; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (raddr1 !== 17'd0 || raddr2 !== 17'd128) begin errors++; $display("FAIL n256 first pair: got %0d,%0d want 0,128", raddr1, raddr2); end
      end
      if (i == 4) begin
        checks += 2;
        if (we !== 32'h1) begin errors++; $display("FAIL n256 first we: got %h want 00000001", we); end
        if (waddr1 !== 17'd0 || waddr2 !== 17'd128) begin errors++; $display("FAIL n256 first write: got %0d,%0d want 0,128", waddr1, waddr2); end
      end
      if (i == 127) begin
        checks++;
        if (raddr1 !== 17'd127 || raddr2 !== 17'd255) begin errors++; $display("FAIL n256 last pair: got %0d,%0d want 127,255", raddr1, raddr2); end
      end
      if (i == 132) begin
        checks += 2;
        if (raddr1 !== 17'd0 || raddr2 !== 17'd64) begin errors++; $display("FAIL n256 stage2 pair: got %0d,%0d want 0,64", raddr1, raddr2); end
        if (we !== 32'd0) begin errors++; $display("FAIL n256 drain we: got %h want 0", we); end
      end
    end
    do_reset();
  endtask
  task automatic test_reset_mid;
    @(negedge clk);
    param_n = 17'd64;
    ntt_start = 1'b1;
    repeat (11) @(negedge clk);
    checks++;
    if (raddr1 !== 17'd10 || raddr2 !== 17'd42) begin errors++; $display("FAIL midrst k10 pair: got %0d,%0d want 10,42", raddr1, raddr2); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ntt_start = 1'b0;
    checks += 3;
    if (raddr1 !== 17'd0 || raddr2 !== 17'd0) begin errors++; $display("FAIL midrst raddr: got %0d,%0d want 0,0", raddr1, raddr2); end
    if (waddr1 !== 17'd0 || waddr2 !== 17'd0) begin errors++; $display("FAIL midrst waddr: got %0d,%0d want 0,0", waddr1, waddr2); end
    if (we !== 32'd0) begin errors++; $display("FAIL midrst we: got %h want 0", we); end
    repeat (L + 2) begin
      @(negedge clk);
      checks++;
      if (we !== 32'd0) begin errors++; $display("FAIL midrst flush we: got %h want 0", we); end
    end
    ntt_start = 1'b1;
    @(negedge clk);
    checks++;
    if (raddr1 !== 17'd0 || raddr2 !== 17'd32) begin errors++; $display("FAIL midrst fresh pair: got %0d,%0d want 0,32", raddr1, raddr2); end
    do_reset();
  endtask
  task automatic test_n1;
    @(negedge clk);
    param_n = 17'd1;
    ntt_start = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks += 2;
      if (raddr1 !== 17'd0 || raddr2 !== 17'd0) begin errors++; $display("FAIL n1 raddr: got %0d,%0d want 0,0", raddr1, raddr2); end
      if (we !== 32'd0) begin errors++; $display("FAIL n1 we: got %h want 0", we); end
    end
    ntt_start = 1'b0;
    param_n = 17'd2;
    @(negedge clk);
    ntt_start = 1'b1;
    @(negedge clk);
    checks++;
    if (raddr1 !== 17'd0 || raddr2 !== 17'd1) begin errors++; $display("FAIL n1 then n2 pair: got %0d,%0d want 0,1", raddr1, raddr2); end
    do_reset();
  endtask
  task automatic test_random;
    for (int t = 0; t < 6; t++) test_transform(int'($urandom_range(2, 40)), "rand");
  endtask
  task automatic test_n65536;
    @(negedge clk);
    param_n = 17'h10000;
    ntt_start = 1'b1;
    for (int i = 0; i <= 32772; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (raddr1 !== 17'd0 || raddr2 !== 17'd32768) begin errors++; $display("FAIL n65536 first pair: got %0d,%0d want 0,32768", raddr1, raddr2); end
      end
      if (i == 32767) begin
        checks++;
        if (raddr1 !== 17'd32767 || raddr2 !== 17'd65535) begin errors++; $display("FAIL n65536 stage1 last pair: got %0d,%0d want 32767,65535", raddr1, raddr2); end
      end
      if (i == 32771) begin
        checks += 2;
        if (we !== 32'h80000000) begin errors++; $display("FAIL n65536 last we: got %h want 80000000", we); end
        if (waddr1 !== 17'd32767 || waddr2 !== 17'd65535) begin errors++; $display("FAIL n65536 last write: got %0d,%0d want 32767,65535", waddr1, waddr2); end
      end
      if (i == 32772) begin
        checks++;
        if (raddr1 !== 17'd0 || raddr2 !== 17'd16384) begin errors++; $display("FAIL n65536 stage2 pair: got %0d,%0d want 0,16384", raddr1, raddr2); end
      end
    end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_n256();
    test_transform(4, "n4");
    test_transform(16, "n16");
    test_reset_mid();
    test_n1();
    test_random();
    test_n65536();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
